// File: rtl/gcd_seq_pkg.sv
// Shared types and defaults for the GCD job sequencer: FSM state encoding,
// default operand width and the default WAIT timeout.
package gcd_seq_pkg;

    localparam int DEFAULT_WIDTH          = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 2000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_BYPASS,
        S_CLEAR
    } seq_state_e;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Synchronous FIFO of operand pairs. Read data comes straight from the storage
// registers at the read pointer, so the head pair is visible while not empty.
module gcd_pair_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and resetting memories wastes logic.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/gcd_job_sequencer.sv
// Front-end sequencer feeding operand pairs to the GCD core one job at a time.
// Optional WAIT timeout is enabled by defining GCD_SEQ_TIMEOUT_EN.
module gcd_job_sequencer
    import gcd_seq_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_err,
    output logic             busy,
    output logic [WIDTH-1:0] core_data,
    output logic             core_start,
    output logic             core_rst,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result
);

    seq_state_e         state;
    seq_state_e         state_next;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [2*WIDTH-1:0] fifo_rd;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   data_q;
    logic               res_we;
    logic [WIDTH-1:0]   res_val;
    logic               res_err;
    logic               timeout_hit;

    assign in_ready = !fifo_full && !rst;
    assign busy     = (state != S_IDLE) || !fifo_empty;
    assign core_rst = rst || (state == S_CLEAR);

    gcd_pair_fifo #(
        .DATA_W (2*WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid && in_ready),
        .wr_data ({in_a, in_b}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef GCD_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Held at zero outside WAIT, so it restarts on every entry to WAIT.
    always_ff @(posedge clk) begin
        if (rst || state != S_WAIT) wait_cnt <= '0;
        else                        wait_cnt <= wait_cnt + CNT_W'(1);
    end

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        res_we     = 1'b0;
        res_val    = '0;
        res_err    = 1'b0;
        core_start = 1'b0;
        core_data  = data_q;
        case (state)
            S_IDLE: begin
                if (!fifo_empty && (!out_valid || out_ready)) begin
                    fifo_pop = 1'b1;
                    if (fifo_rd[2*WIDTH-1:WIDTH] == '0 || fifo_rd[WIDTH-1:0] == '0)
                        state_next = S_BYPASS;
                    else
                        state_next = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                core_data  = op_a;
                core_start = 1'b1;
                state_next = S_LOAD_B;
            end
            S_LOAD_B: begin
                core_data  = op_b;
                core_start = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                core_data = op_b;
                // A coincident done beats the timeout.
                if (core_done) begin
                    res_we     = 1'b1;
                    res_val    = core_result;
                    state_next = S_CLEAR;
                end else if (timeout_hit) begin
                    res_we     = 1'b1;
                    res_err    = 1'b1;
                    state_next = S_CLEAR;
                end
            end
            S_BYPASS: begin
                res_we     = 1'b1;
                res_val    = (op_a == '0) ? op_b : op_a;
                state_next = S_IDLE;
            end
            S_CLEAR:  state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_a   <= '0;
            op_b   <= '0;
            data_q <= '0;
        end else begin
            state  <= state_next;
            data_q <= core_data;
            if (fifo_pop) {op_a, op_b} <= fifo_rd;
        end
    end

    // Result register: a new write always lands on an empty or draining slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_gcd   <= '0;
            out_err   <= 1'b0;
        end else if (res_we) begin
            out_valid <= 1'b1;
            out_gcd   <= res_val;
            out_err   <= res_err;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
